// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: stage enables, flushes, PC enable, mem-wait watchdog, debug halt/step.
// Latency: zero cycles inputs->enables/flushes; state, wait counter and mem_timeout update on the next edge.
// Backpressure: a data-memory wait freezes every stage register; a debug halt freezes all but single-step cycles.
// Optional build macro PIPE_PERF_CNT_EN adds stall_cycles / flush_events performance counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [4:0]       dec_regA,
    input  logic [4:0]       dec_regB,
    input  logic             dec_is_immediate,
    input  logic             alu_mem_r_en,
    input  logic [4:0]       alu_regD,
    input  logic             alu_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             imem_ready,
    input  logic             dbg_halt_req,
    input  logic             dbg_step,
    output logic             EN_REG_FETCH,
    output logic             EN_REG_DECODE,
    output logic             EN_REG_ALU,
    output logic             EN_REG_MEM,
    output logic             flush_fetch,
    output logic             flush_decode,
    output logic             flush_mem,
    output logic             pc_en,
    output logic             dbg_halted,
    output logic             mem_timeout,
    output logic [1:0]       state
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_e;

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_MAX  = WCW'(MEM_TIMEOUT);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    state_e         state_q;
    state_e         state_d;
    logic [WCW-1:0] wait_cnt;
    logic           load_use;
    logic           active;
    logic           mem_stall;
    logic           rule2_hit;

    assign state = state_q;

    assign load_use = alu_mem_r_en && (alu_regD != 5'd0) && dec_valid &&
                      ((alu_regD == dec_regA) ||
                       (!dec_is_immediate && (alu_regD == dec_regB)));

    always_comb begin
        EN_REG_FETCH  = 1'b0;
        EN_REG_DECODE = 1'b0;
        EN_REG_ALU    = 1'b0;
        EN_REG_MEM    = 1'b0;
        flush_fetch   = 1'b0;
        flush_decode  = 1'b0;
        flush_mem     = 1'b0;
        pc_en         = 1'b0;
        rule2_hit     = 1'b0;
        state_d       = state_q;
        // A step cycle in HALTED behaves exactly like one RUN cycle.
        active        = (state_q != HALTED) || dbg_step;
        // Once in MEM_WAIT only mem_ready releases; mem_req is not re-examined.
        mem_stall     = (state_q == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);

        if (active) begin
            if (mem_stall) begin
                flush_mem = 1'b1;
                state_d   = MEM_WAIT;
            end else begin
                if (alu_branch_taken) begin
                    EN_REG_FETCH  = 1'b1;
                    EN_REG_DECODE = 1'b1;
                    EN_REG_ALU    = 1'b1;
                    EN_REG_MEM    = 1'b1;
                    pc_en         = 1'b1;
                    flush_fetch   = 1'b1;
                    flush_decode  = 1'b1;
                    rule2_hit     = 1'b1;
                end else if (load_use) begin
                    EN_REG_DECODE = 1'b1;
                    EN_REG_ALU    = 1'b1;
                    EN_REG_MEM    = 1'b1;
                    flush_decode  = 1'b1;
                end else if (!imem_ready) begin
                    EN_REG_DECODE = 1'b1;
                    EN_REG_ALU    = 1'b1;
                    EN_REG_MEM    = 1'b1;
                    flush_fetch   = 1'b1;
                end else begin
                    EN_REG_FETCH  = 1'b1;
                    EN_REG_DECODE = 1'b1;
                    EN_REG_ALU    = 1'b1;
                    EN_REG_MEM    = 1'b1;
                    pc_en         = 1'b1;
                end
                if (state_q != HALTED) begin
                    state_d = dbg_halt_req ? HALTED : RUN;
                end
            end
        end else begin
            state_d = dbg_halt_req ? HALTED : RUN;
        end

        // Reset holds every stage as a bubble regardless of state.
        if (!reset) begin
            EN_REG_FETCH  = 1'b0;
            EN_REG_DECODE = 1'b0;
            EN_REG_ALU    = 1'b0;
            EN_REG_MEM    = 1'b0;
            pc_en         = 1'b0;
            flush_fetch   = 1'b1;
            flush_decode  = 1'b1;
            flush_mem     = 1'b1;
            rule2_hit     = 1'b0;
        end
    end

    assign dbg_halted = reset && (state_q == HALTED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == MEM_WAIT) && !mem_ready) begin
                if (wait_cnt != WAIT_MAX) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                if (wait_cnt >= WAIT_LAST) begin
                    mem_timeout <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_en && (state_q != HALTED)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (rule2_hit) begin
                flush_events <= flush_events + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboarded directed bench for pipe_hazard_ctrl: driver queues expected outputs, negedge monitor compares.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       dec_valid, dec_is_immediate, alu_mem_r_en, alu_branch_taken;
    logic [4:0] dec_regA, dec_regB, alu_regD;
    logic       mem_req, mem_ready, imem_ready, dbg_halt_req, dbg_step;
    logic       EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM;
    logic       flush_fetch, flush_decode, flush_mem, pc_en;
    logic       dbg_halted, mem_timeout;
    logic [1:0] state;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_regA(dec_regA), .dec_regB(dec_regB),
        .dec_is_immediate(dec_is_immediate), .alu_mem_r_en(alu_mem_r_en),
        .alu_regD(alu_regD), .alu_branch_taken(alu_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .imem_ready(imem_ready),
        .dbg_halt_req(dbg_halt_req), .dbg_step(dbg_step),
        .EN_REG_FETCH(EN_REG_FETCH), .EN_REG_DECODE(EN_REG_DECODE),
        .EN_REG_ALU(EN_REG_ALU), .EN_REG_MEM(EN_REG_MEM),
        .flush_fetch(flush_fetch), .flush_decode(flush_decode), .flush_mem(flush_mem),
        .pc_en(pc_en), .dbg_halted(dbg_halted), .mem_timeout(mem_timeout),
        .state(state)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
    );

    always #5 clk = ~clk;

    // {EN fetch,decode,alu,mem, pc_en, flush fetch,decode,mem}
    localparam logic [7:0] O_RST = 8'b0000_0111;
    localparam logic [7:0] O_STL = 8'b0000_0001;
    localparam logic [7:0] O_BR  = 8'b1111_1110;
    localparam logic [7:0] O_LU  = 8'b0111_0010;
    localparam logic [7:0] O_IM  = 8'b0111_0100;
    localparam logic [7:0] O_RUN = 8'b1111_1000;
    localparam logic [7:0] O_HLT = 8'b0000_0000;

    logic [11:0] exp_q[$];
    string       name_q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    // Expected outputs for the cycle whose inputs are currently applied.
    task automatic cyc(input string nm, input logic [7:0] o, input logic h,
                       input logic to, input logic [1:0] st);
        exp_q.push_back({o, h, to, st});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 1'b1; dec_regA = 5'd1; dec_regB = 5'd2; dec_is_immediate = 1'b0;
        alu_mem_r_en = 1'b0; alu_regD = 5'd7; alu_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; imem_ready = 1'b1;
        dbg_halt_req = 1'b0; dbg_step = 1'b0;
    endtask

    initial begin : monitor
        logic [11:0] e, a;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM, pc_en,
                      flush_fetch, flush_decode, flush_mem, dbg_halted, mem_timeout, state};
                n_vec++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL %s: got %b want %b (en4 pc fl3 halted timeout state2)", nm, a, e);
                end
            end
        end
    end

    initial begin : driver
        idle();
        reset = 1'b0;
        @(posedge clk);
        #1;
        alu_branch_taken = 1'b1;
        cyc("reset_0", O_RST, 0, 0, 2'd0);
        alu_branch_taken = 1'b0;
        cyc("reset_1", O_RST, 0, 0, 2'd0);
        reset = 1'b1;
        cyc("run_idle", O_RUN, 0, 0, 2'd0);

        alu_mem_r_en = 1'b1; alu_regD = 5'd5; dec_regA = 5'd5;
        cyc("lu_regA", O_LU, 0, 0, 2'd0);
        alu_mem_r_en = 1'b0;
        cyc("lu_clear", O_RUN, 0, 0, 2'd0);
        alu_mem_r_en = 1'b1; dec_regA = 5'd1; dec_regB = 5'd5; dec_is_immediate = 1'b1;
        cyc("lu_regB_imm", O_RUN, 0, 0, 2'd0);
        dec_is_immediate = 1'b0;
        cyc("lu_regB", O_LU, 0, 0, 2'd0);
        alu_regD = 5'd0; dec_regA = 5'd0; dec_regB = 5'd0;
        cyc("lu_r0", O_RUN, 0, 0, 2'd0);
        alu_regD = 5'd5; dec_regA = 5'd5; dec_valid = 1'b0;
        cyc("lu_noval", O_RUN, 0, 0, 2'd0);
        dec_valid = 1'b1; alu_branch_taken = 1'b1;
        cyc("br_over_lu", O_BR, 0, 0, 2'd0);
        alu_mem_r_en = 1'b0; imem_ready = 1'b0;
        cyc("br_over_im", O_BR, 0, 0, 2'd0);
        alu_branch_taken = 1'b0;
        cyc("imiss", O_IM, 0, 0, 2'd0);
        alu_mem_r_en = 1'b1;
        cyc("lu_over_im", O_LU, 0, 0, 2'd0);

        idle();
        mem_req = 1'b1; alu_branch_taken = 1'b1;
        cyc("mw_enter", O_STL, 0, 0, 2'd0);
        for (int i = 1; i <= 19; i++) begin
            cyc($sformatf("mw_%0d", i), O_STL, 0, (i >= 17), 2'd1);
        end
        mem_ready = 1'b1;
        cyc("mw_rel_br", O_BR, 0, 1, 2'd1);
        idle();
        cyc("mw_after", O_RUN, 0, 1, 2'd0);
        reset = 1'b0;
        cyc("to_reset", O_RST, 0, 0, 2'd0);
        reset = 1'b1;
        cyc("to_cleared", O_RUN, 0, 0, 2'd0);

        mem_req = 1'b1;
        cyc("h_mw_enter", O_STL, 0, 0, 2'd0);
        dbg_halt_req = 1'b1;
        cyc("h_mw_1", O_STL, 0, 0, 2'd1);
        cyc("h_mw_2", O_STL, 0, 0, 2'd1);
        mem_ready = 1'b1;
        cyc("h_mw_rel", O_RUN, 0, 0, 2'd1);
        mem_req = 1'b0; mem_ready = 1'b0;
        cyc("halted", O_HLT, 1, 0, 2'd2);
        dbg_step = 1'b1;
        cyc("step_1", O_RUN, 1, 0, 2'd2);
        dbg_step = 1'b0;
        cyc("halted_2", O_HLT, 1, 0, 2'd2);
        dbg_step = 1'b1; imem_ready = 1'b0;
        cyc("step_2", O_IM, 1, 0, 2'd2);
        dbg_step = 1'b0; imem_ready = 1'b1;
        cyc("halted_3", O_HLT, 1, 0, 2'd2);
        dbg_halt_req = 1'b0;
        cyc("unhalt", O_HLT, 1, 0, 2'd2);
        cyc("resumed", O_RUN, 0, 0, 2'd0);

        dbg_halt_req = 1'b1;
        cyc("halt_run", O_RUN, 0, 0, 2'd0);
        cyc("halted_4", O_HLT, 1, 0, 2'd2);
        dbg_step = 1'b1; mem_req = 1'b1;
        cyc("step_mem", O_STL, 1, 0, 2'd2);
        dbg_step = 1'b0;
        cyc("step_mw", O_STL, 0, 0, 2'd1);
        reset = 1'b0;
        cyc("rst_mw", O_RST, 0, 0, 2'd0);
        idle();
        reset = 1'b1;
        cyc("rst_rel", O_RUN, 0, 0, 2'd0);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the processor's five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Every cycle it drives the stage-register enables, flushes and the PC update enable from the decode, ALU and memory stages' status, resolving load-use hazards, taken branches, instruction-fetch misses and multi-cycle data-memory accesses. A small FSM tracks data-memory wait with a timeout watchdog and a debug halt/single-step handshake. Sits beside the pipeline stage registers in the top-level core.

## Interface
- MEM_TIMEOUT, 16: consecutive data-memory wait cycles before `mem_timeout` is raised.
- CNT_W, 32: width of performance counters.
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- dec_valid  in  1  decode stage holds a real instruction.
- dec_regA, dec_regB  in  5 each  decode-stage source registers.
- dec_is_immediate  in  1  decode instruction does not read regB.
- alu_mem_r_en  in  1  ALU-stage instruction is a load.
- alu_regD  in  5  ALU-stage destination register.
- alu_branch_taken  in  1  ALU stage resolved a taken branch/jump.
- mem_req  in  1  MEM stage has a load/store in flight.
- mem_ready  in  1  data memory completes access this cycle.
- imem_ready  in  1  instruction memory returns a valid word this cycle.
- dbg_halt_req  in  1  level; request pipeline halt.
- dbg_step  in  1  pulse; advance one cycle while halted.
- EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM  out  1 each  load enables for IF/ID, ID/EX, EX/MEM, MEM/WB.
- flush_fetch, flush_decode, flush_mem  out  1 each  clear IF/ID, ID/EX, MEM/WB to bubble; flush overrides enable on the same register.
- pc_en  out  1  PC register update.
- dbg_halted  out  1  pipeline frozen in HALTED.
- mem_timeout  out  1  sticky watchdog flag.
- state  out  2  RUN=0, MEM_WAIT=1, HALTED=2.

## Operation
- Outputs are combinational from `state` plus inputs; `state`, wait counter and `mem_timeout` are registered.
- While `reset` low: state=RUN, counter=0, mem_timeout=0, dbg_halted=0; all EN_* 0, pc_en 0, flush_fetch/decode/mem 1.
- RUN, priority top-down:
  1. mem_req && !mem_ready: all EN_* 0, pc_en 0, flush_mem 1; next MEM_WAIT.
  2. alu_branch_taken: all EN_* 1, pc_en 1, flush_fetch 1, flush_decode 1.
  3. Load-use: alu_mem_r_en && alu_regD!=0 && dec_valid && (alu_regD==dec_regA || (!dec_is_immediate && alu_regD==dec_regB)): pc_en 0, EN_REG_FETCH 0, flush_decode 1, EN_REG_ALU/EN_REG_MEM 1.
  4. !imem_ready: pc_en 0, flush_fetch 1, other EN_* 1.
  5. Otherwise: all EN_* 1, pc_en 1, no flush.
  - dbg_halt_req in a cycle taking rule 2–5: that cycle's action completes, next HALTED.
- MEM_WAIT: outputs as rule 1 until mem_ready; counter increments each wait cycle, saturating at MEM_TIMEOUT; at MEM_TIMEOUT set mem_timeout (cleared only by reset). Cycle with mem_ready: evaluate rules 2–5 as in RUN, counter cleared; next HALTED if dbg_halt_req else RUN.
- HALTED: all EN_* 0, pc_en 0, no flush, dbg_halted 1. dbg_step: that cycle evaluates rules 1–5; rule 1 → MEM_WAIT, else stay HALTED. dbg_halt_req low (and no dbg_step) → RUN next cycle.

## Timing
- Zero-cycle latency from inputs to enables/flushes; state change visible next edge.
- Load-use inserts exactly one bubble; next cycle load is in MEM, hazard clears.
- Branch penalty: two killed instructions, same cycle as resolution.
- Branch held in EX during MEM_WAIT resolves on the mem_ready cycle (release + flush together).
- Halt request never interrupts a memory access; halt entry takes at least one edge after assertion.
- Reset mid-MEM_WAIT or mid-HALTED: immediate return to reset outputs, no pending action kept.

## Configuration
- PIPE_PERF_CNT_EN defined: adds outputs `stall_cycles` and `flush_events` (CNT_W, wrap-around, reset 0); stall_cycles +1 each cycle pc_en=0 outside HALTED/reset, flush_events +1 per rule-2 cycle.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Load r5 in EX, decode reads regA=5 -> one cycle pc_en=0, EN_REG_FETCH=0, flush_decode=1; next cycle all enables 1.
- Same with regB=5, dec_is_immediate=1 -> no stall; alu_regD=0 -> no stall.
- alu_branch_taken with load-use also true -> flush_fetch=flush_decode=1, pc_en=1, no stall.
- mem_req, mem_ready low 20 cycles (MEM_TIMEOUT=16) -> state=1, mem_timeout rises on 17th wait-cycle edge, stays 1 after release.
- dbg_halt_req during MEM_WAIT -> stays MEM_WAIT until mem_ready, then HALTED; two dbg_step pulses -> exactly two advancing cycles.
- reset low during MEM_WAIT -> outputs at reset values immediately, state=0 after release.
